// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional even
// parity, stop bit. The frame is timed by a baud counter and a data-bit counter.
module serial_frame_tx #(
  parameter int N_BITS       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [N_BITS-1:0] in_data,
  output logic              in_ready,
  output logic              ser_out,
  output logic              shift_en,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_reg, state_next;
  logic [BAUD_W-1:0]   baud_cnt_reg, baud_cnt_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [N_BITS-1:0]   word_reg, word_next;
  logic                bit_end;
  logic [N_BITS:0]     parity_chain;

  // Even parity of the latched word, built as an XOR chain
  assign parity_chain[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_parity
      assign parity_chain[gi+1] = parity_chain[gi] ^ word_reg[gi];
    end
  endgenerate

  assign bit_end = (baud_cnt_reg == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      word_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      word_reg     <= word_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_next     = word_reg;
    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        if (in_valid) begin
          word_next  = in_data;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          state_next    = STOP;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          state_next    = IDLE;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
      end
    endcase
  end

  // Outputs decode state and counters only, never the input handshake
  always_comb begin
    ser_out = 1'b1;
    case (state_reg)
      START:   ser_out = 1'b0;
      DATA:    ser_out = word_reg[bit_cnt_reg];
      PARITY:  ser_out = parity_chain[N_BITS];
      default: ser_out = 1'b1;
    endcase
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = ~in_ready;
  assign shift_en = (state_reg == DATA) && bit_end;
  assign done     = (state_reg == STOP) && bit_end;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a default-parameter instance and a CLKS_PER_BIT=1,
// no-parity instance, both checked cycle by cycle against a frame-slot model.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_in_valid, b_in_valid;
  logic [3:0] a_in_data, b_in_data;
  logic       a_in_ready, a_ser_out, a_shift_en, a_busy, a_done;
  logic       b_in_ready, b_ser_out, b_shift_en, b_busy, b_done;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.N_BITS(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .ser_out(a_ser_out), .shift_en(a_shift_en),
    .busy(a_busy), .done(a_done)
  );

  serial_frame_tx #(.N_BITS(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .ser_out(b_ser_out), .shift_en(b_shift_en),
    .busy(b_busy), .done(b_done)
  );

  // Frame as a list of bit slots: start, d0..d3, [parity], stop. Returns {ser, shift, done}
  function automatic logic [2:0] model(input logic [3:0] w, input int cpb, input int par, input int i);
    int  slot;
    logic last;
    slot = i / cpb;
    last = ((i % cpb) == cpb - 1);
    if (slot == 0)                return 3'b000;
    else if (slot <= 4)           return {w[slot-1], last, 1'b0};
    else if (par != 0 && slot == 5) return {^w, 2'b00};
    else                          return {1'b1, 1'b0, last};
  endfunction

  // mode 0: plain, 1: scramble in_data each cycle, 2: in_valid poke at frame cycle 5
  task automatic frame_a(input logic [3:0] w, input int mode, input bit hold);
    logic [3:0] cap;
    logic [2:0] e;
    cap = 4'h0;
    total++;
    if ({a_in_ready, a_ser_out, a_busy} !== 3'b110) begin
      bad++;
      $display("FAIL frame_a_idle word=%b got ready/ser/busy=%b exp=110", w, {a_in_ready, a_ser_out, a_busy});
    end
    a_in_valid = 1'b1;
    a_in_data  = w;
    @(posedge clk);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (!hold) a_in_valid = 1'b0;
      if (mode == 1) a_in_data = 4'($urandom);
      if (mode == 2) begin
        a_in_valid = (i == 4);
        a_in_data  = 4'b0110;
      end
      e = model(w, 4, 1, i);
      total++;
      if ({a_ser_out, a_shift_en, a_done, a_busy} !== {e, 1'b1}) begin
        bad++;
        $display("FAIL frame_a word=%b cyc=%0d got ser/shift/done/busy=%b exp=%b",
                 w, i, {a_ser_out, a_shift_en, a_done, a_busy}, {e, 1'b1});
      end
      if (a_shift_en === 1'b1) cap = {a_ser_out, cap[3:1]};
    end
    total++;
    if (cap !== w) begin
      bad++;
      $display("FAIL frame_a_capture got=%b exp=%b", cap, w);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 4'b1011;
    b_in_valid = 1'b1;
    b_in_data  = 4'b1000;
    repeat (3) @(negedge clk);
    total++;
    if ({a_in_ready, a_ser_out, a_shift_en, a_done, a_busy} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_a got=%b exp=11000", {a_in_ready, a_ser_out, a_shift_en, a_done, a_busy});
    end
    total++;
    if ({b_in_ready, b_ser_out, b_shift_en, b_done, b_busy} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_b got=%b exp=11000", {b_in_ready, b_ser_out, b_shift_en, b_done, b_busy});
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    $display("reset: checked idle state with in_valid high during reset");
  endtask

  task automatic test_basic;
    logic [3:0] w;
    frame_a(4'b1011, 0, 1'b0);
    $display("basic: word=1011");
    for (int k = 0; k < 4; k++) begin
      w = 4'($urandom);
      frame_a(w, 0, 1'b0);
      $display("basic: word=%b", w);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] w1, w2;
    frame_a(4'b0001, 0, 1'b1);
    frame_a(4'b1110, 0, 1'b0);
    $display("back_to_back: words=0001,1110");
    w1 = 4'($urandom);
    w2 = 4'($urandom);
    frame_a(w1, 0, 1'b1);
    frame_a(w2, 0, 1'b0);
    $display("back_to_back: words=%b,%b", w1, w2);
  endtask

  task automatic test_busy_ignore;
    frame_a(4'b1001, 2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({a_in_ready, a_busy, a_ser_out} !== 3'b101) begin
        bad++;
        $display("FAIL busy_ignore k=%0d got ready/busy/ser=%b exp=101", k, {a_in_ready, a_busy, a_ser_out});
      end
      @(negedge clk);
    end
    $display("busy_ignore: word=1001 with poke 0110");
  endtask

  task automatic test_mid_reset;
    logic [3:0] w;
    w = 4'($urandom);
    a_in_valid = 1'b1;
    a_in_data  = w;
    @(posedge clk);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
    end
    // now in data bit 2
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_pre got busy=%b exp=1", a_busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({a_in_ready, a_ser_out, a_shift_en, a_done, a_busy} !== 5'b11000) begin
      bad++;
      $display("FAIL mid_reset_async got=%b exp=11000", {a_in_ready, a_ser_out, a_shift_en, a_done, a_busy});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if ({a_ser_out, a_shift_en, a_done, a_busy} !== 4'b1000) begin
        bad++;
        $display("FAIL mid_reset_after cyc=%0d got=%b exp=1000", i, {a_ser_out, a_shift_en, a_done, a_busy});
      end
    end
    w = 4'($urandom);
    frame_a(w, 0, 1'b0);
    $display("mid_reset: aborted frame, then word=%b", w);
  endtask

  task automatic test_stability;
    logic [3:0] w;
    for (int k = 0; k < 3; k++) begin
      w = 4'($urandom);
      frame_a(w, 1, 1'b0);
      $display("stability: word=%b with in_data scrambled", w);
    end
  endtask

  task automatic test_edge_params;
    logic [3:0] w, cap;
    logic [2:0] e;
    for (int k = 0; k < 4; k++) begin
      w   = (k == 0) ? 4'b1000 : 4'($urandom);
      cap = 4'h0;
      total++;
      if (b_in_ready !== 1'b1) begin
        bad++;
        $display("FAIL edge_ready got=%b exp=1", b_in_ready);
      end
      b_in_valid = 1'b1;
      b_in_data  = w;
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_data  = 4'($urandom);
        e = model(w, 1, 0, i);
        total++;
        if ({b_ser_out, b_shift_en, b_done, b_busy} !== {e, 1'b1}) begin
          bad++;
          $display("FAIL edge_frame word=%b cyc=%0d got ser/shift/done/busy=%b exp=%b",
                   w, i, {b_ser_out, b_shift_en, b_done, b_busy}, {e, 1'b1});
        end
        if (b_shift_en === 1'b1) cap = {b_ser_out, cap[3:1]};
      end
      total++;
      if (cap !== w) begin
        bad++;
        $display("FAIL edge_capture got=%b exp=%b", cap, w);
      end
      @(negedge clk);
      $display("edge_params: word=%b", w);
    end
  endtask

  initial begin
    reset      = 1'b1;
    a_in_valid = 1'b0;
    a_in_data  = 4'h0;
    b_in_valid = 1'b0;
    b_in_data  = 4'h0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_stability();
    test_edge_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
